// File: rtl/logic_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : logic_result_checker                                            |
// | Purpose  : Scores a logic unit's (out, zerof) against AND/OR/XOR/NOR refs. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module logic_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             end_session,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] out,
  input  logic             zerof,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_index,
  output logic             busy,
  output logic             session_done
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic             r_zerof;
  logic             r_close_pend;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [CNT_W-1:0] r_idx;
  logic             r_ff_valid;
  logic [CNT_W-1:0] r_ff_index;
  logic [WIDTH-1:0] w_expected;
  logic             w_fail;
  logic             w_accept;

  always_comb begin
    w_expected = '0;
    case (r_op)
      2'b00:   w_expected = r_a & r_b;
      2'b01:   w_expected = r_a | r_b;
      2'b10:   w_expected = r_a ^ r_b;
      default: w_expected = ~(r_a | r_b);
    endcase
  end

  assign w_fail   = (r_out != w_expected) || (r_zerof != (w_expected == '0));
  assign w_accept = (r_state == ARMED) && sample_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // A close requested either with the accepted sample or during CHECK is honoured once the check retires.
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = ARMED;
    end else begin
      case (r_state)
        ARMED: begin
          if (sample_valid)     w_state_next = CHECK;
          else if (end_session) w_state_next = DONE;
        end
        CHECK:   w_state_next = (r_close_pend || end_session) ? DONE : ARMED;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_out        <= '0;
      r_zerof      <= 1'b0;
      r_close_pend <= 1'b0;
      r_mismatch   <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_idx        <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_index   <= '0;
    end else if (start) begin
      r_close_pend <= 1'b0;
      r_mismatch   <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_idx        <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_index   <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_accept) begin
        r_op         <= op;
        r_a          <= a;
        r_b          <= b;
        r_out        <= out;
        r_zerof      <= zerof;
        r_close_pend <= end_session;
      end
      if (r_state == CHECK) begin
        if (w_fail) begin
          r_mismatch <= 1'b1;
          if (r_fail != c_cnt_max) r_fail <= r_fail + c_cnt_one;
          if (!r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_index <= r_idx;
          end
        end else if (r_pass != c_cnt_max) begin
          r_pass <= r_pass + c_cnt_one;
        end
        if (r_idx != c_cnt_max) r_idx <= r_idx + c_cnt_one;
      end
    end
  end

  assign sample_ready     = (r_state == ARMED);
  assign busy             = (r_state == ARMED) || (r_state == CHECK);
  assign session_done     = (r_state == DONE);
  assign mismatch         = r_mismatch;
  assign pass_count       = r_pass;
  assign fail_count       = r_fail;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_index = r_ff_index;

endmodule
`default_nettype wire

// File: tb/tb_logic_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_logic_result_checker                                         |
// | Purpose  : Randomized self-checking bench for logic_result_checker.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_logic_result_checker;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, end_session, sample_valid, zerof;
  logic [1:0]   op;
  logic [W-1:0] a, b, out;

  logic         sample_ready, mismatch, first_fail_valid, busy, session_done;
  logic [15:0]  pass_count, fail_count, first_fail_index;
  logic         sample_ready4, mismatch4, first_fail_valid4, busy4, session_done4;
  logic [3:0]   pass_count4, fail_count4, first_fail_index4;

  logic_result_checker #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .end_session(end_session),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .op(op), .a(a), .b(b),
    .out(out), .zerof(zerof), .mismatch(mismatch), .pass_count(pass_count),
    .fail_count(fail_count), .first_fail_valid(first_fail_valid),
    .first_fail_index(first_fail_index), .busy(busy), .session_done(session_done)
  );

  logic_result_checker #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .end_session(end_session),
    .sample_valid(sample_valid), .sample_ready(sample_ready4), .op(op), .a(a), .b(b),
    .out(out), .zerof(zerof), .mismatch(mismatch4), .pass_count(pass_count4),
    .fail_count(fail_count4), .first_fail_valid(first_fail_valid4),
    .first_fail_index(first_fail_index4), .busy(busy4), .session_done(session_done4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: unbounded tallies, clipped to the counter width only when compared.
  int m_pass, m_fail, m_idx, m_ffi;
  bit m_ffv, m_mis;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 0; m_ffv = 0; m_mis = 0;
  endtask

  task automatic check_state(input string tag, input bit e_ready, input bit e_busy, input bit e_done);
    chk({tag, "/ready"}, sample_ready, e_ready);
    chk({tag, "/busy"},  busy, e_busy);
    chk({tag, "/done"},  session_done, e_done);
    chk({tag, "/mis"},   mismatch, m_mis);
    chk({tag, "/pass"},  pass_count, sat(m_pass, 16));
    chk({tag, "/fail"},  fail_count, sat(m_fail, 16));
    chk({tag, "/ffv"},   first_fail_valid, m_ffv);
    chk({tag, "/ffi"},   first_fail_index, m_ffv ? sat(m_ffi, 16) : 0);
    chk({tag, "/state4"}, {sample_ready4, busy4, session_done4}, {e_ready, e_busy, e_done});
    chk({tag, "/mis4"},  mismatch4, m_mis);
    chk({tag, "/pass4"}, pass_count4, sat(m_pass, 4));
    chk({tag, "/fail4"}, fail_count4, sat(m_fail, 4));
    chk({tag, "/ff4"},   {first_fail_valid4, first_fail_index4}, {m_ffv, 4'(m_ffv ? sat(m_ffi, 4) : 0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_mis = 0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_state(tag, 1, 1, 0);
  endtask

  // eos: 0 none, 1 with the sample, 2 during CHECK
  task automatic send(input string tag, input logic [1:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic [W-1:0] oo, input logic zz, input int eos);
    logic [W-1:0] e;
    bit           ok;
    chk({tag, "/rdy_in"}, sample_ready, 1'b1);
    op = o; a = aa; b = bb; out = oo; zerof = zz;
    sample_valid = 1'b1;
    end_session  = (eos == 1);
    tick();
    sample_valid = 1'b0;
    end_session  = (eos == 2);
    check_state({tag, "/chk"}, 0, 1, 0);
    tick();
    end_session = 1'b0;
    e  = ref_op(o, aa, bb);
    ok = (oo == e) && (zz == (e == '0));
    if (ok) m_pass++;
    else begin
      m_fail++;
      if (!m_ffv) begin m_ffv = 1; m_ffi = m_idx; end
    end
    m_idx++;
    m_mis = !ok;
    check_state({tag, "/res"}, eos == 0, eos == 0, eos != 0);
  endtask

  task automatic send_rand(input string tag, input bit force_pass, input int eos);
    logic [1:0]   o;
    logic [W-1:0] aa, bb, e, oo;
    logic         zz;
    int           kind;
    o  = 2'($urandom_range(0, 3));
    aa = $urandom;
    kind = $urandom_range(0, 4);
    bb = (kind == 0) ? aa : (kind == 1) ? ~aa : (kind == 2) ? '0 : W'($urandom);
    e  = ref_op(o, aa, bb);
    oo = e;
    zz = (e == '0);
    if (!force_pass) begin
      kind = $urandom_range(0, 3);
      if (kind == 2) oo = e ^ (W'(1) << $urandom_range(0, W - 1));
      if (kind == 3) zz = ~zz;
    end
    send(tag, o, aa, bb, oo, zz, eos);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; end_session = 1'b0; sample_valid = 1'b0;
    op = '0; a = '0; b = '0; out = '0; zerof = 1'b0;
    model_clear();
    #12;
    check_state("reset", 0, 0, 0);
    reset = 1'b0;
    tick();
    end_session = 1'b1; sample_valid = 1'b1;
    tick();
    end_session = 1'b0; sample_valid = 1'b0;
    check_state("idle_hold", 0, 0, 0);

    do_start("s1");
    send("and_pass", 2'b00, 32'h2, 32'h8, 32'h0, 1'b1, 0);

    do_start("s2");
    send("and_ok", 2'b00, 32'h8, 32'h8, 32'h8, 1'b0, 0);
    send("and_badz", 2'b00, 32'h8, 32'h8, 32'h8, 1'b1, 0);
    tick();
    check_state("mis_drop", 1, 1, 0);

    do_start("s3");
    send("nor_ok", 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
    send("xor_bad", 2'b10, 32'h5, 32'h5, 32'h1, 1'b0, 0);
    send("or_bad", 2'b01, 32'h1, 32'h2, 32'h0, 1'b0, 0);
    chk("ffi_kept", first_fail_index, 1);

    do_start("s4");
    op = 2'b00; a = 32'hF; b = 32'hF; out = 32'hF; zerof = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("thru_ready", sample_ready, (i % 2) == 0);
      tick();
      if (i % 2 == 1) begin m_pass++; m_idx++; end
    end
    sample_valid = 1'b0;
    check_state("thru", 1, 1, 0);
    chk("thru_cnt", pass_count, 3);

    send("close_chk", 2'b01, 32'h0, 32'h0, 32'h0, 1'b1, 2);
    sample_valid = 1'b1; end_session = 1'b1; out = 32'h1234;
    tick(); tick();
    sample_valid = 1'b0; end_session = 1'b0;
    check_state("done_hold", 0, 0, 1);
    do_start("restart");
    end_session = 1'b1;
    tick();
    end_session = 1'b0;
    check_state("close_armed", 0, 0, 1);

    do_start("s5");
    for (int i = 0; i < 17; i++) send_rand("sat", 1, 0);
    chk("sat4_pass", pass_count4, 4'hF);
    chk("sat16_pass", pass_count, 17);
    send("late_fail", 2'b10, 32'h3, 32'h1, 32'h0, 1'b0, 0);

    do_start("s6");
    op = 2'b00; a = 32'h1; b = 32'h1; out = 32'h0; zerof = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_state("start_in_chk", 1, 1, 0);

    for (int s = 0; s < 20; s++) begin
      int n;
      int mode;
      do_start("rs");
      n = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) send_rand("rnd", 0, (k == n - 1) ? mode : 0);
      if (mode == 0) begin
        end_session = 1'b1;
        tick();
        end_session = 1'b0;
        check_state("rnd_close", 0, 0, 1);
      end
    end

    do_start("s7");
    send("pre_rst", 2'b00, 32'h3, 32'h1, 32'h1, 1'b0, 0);
    op = 2'b01; a = 32'h1; b = 32'h0; out = 32'h0; zerof = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    check_state("rst_mid", 0, 0, 0);
    #3;
    reset = 1'b0;
    tick();
    check_state("post_rst", 0, 0, 0);
    tick();
    check_state("post_rst2", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/logic_result_checker.md
LOGIC_RESULT_CHECKER -- requirements
Module: logic_result_checker

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, operand/result width.
REQ-002 The block SHALL provide parameter CNT_W, default 16, width of all counters and indices.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, clears results and arms a session.
REQ-006 The block SHALL have port end_session, input, 1, requests session close.
REQ-007 The block SHALL have port sample_valid, input, 1, a sample is presented.
REQ-008 The block SHALL have port sample_ready, output, 1, block accepts a sample this cycle.
REQ-009 The block SHALL have port op, input, 2, expected operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 The block SHALL have ports a and b, input, WIDTH, operands driven to the unit under test.
REQ-011 The block SHALL have ports out (input, WIDTH) and zerof (input, 1), the result and zero flag returned by the unit under test.
REQ-012 The block SHALL have port mismatch, output, 1, one-cycle failure pulse.
REQ-013 The block SHALL have ports pass_count and fail_count, output, CNT_W, session tallies.
REQ-014 The block SHALL have ports first_fail_valid (output, 1) and first_fail_index (output, CNT_W), the 0-based index of the first failing sample.
REQ-015 The block SHALL have ports busy and session_done, output, 1, session status.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, CHECK and DONE.
REQ-017 sample_ready SHALL be 1 only in ARMED; busy SHALL be 1 in ARMED and CHECK; session_done SHALL be 1 only in DONE.
REQ-018 A sample SHALL be accepted on an edge where sample_valid and sample_ready are both 1; that edge captures op, a, b, out and zerof and moves the FSM ARMED->CHECK.
REQ-019 In CHECK, expected = op(a,b) bitwise at WIDTH bits and zerof_expected = (expected == 0).
REQ-020 In CHECK, a failure SHALL be flagged when out != expected or zerof != zerof_expected.
REQ-021 On the edge leaving CHECK, the block SHALL increment pass_count or fail_count, advance the internal sample index, and return to ARMED, or to DONE if a close is pending.
REQ-022 mismatch SHALL be 1 for exactly the one cycle after a failing CHECK edge, otherwise 0.
REQ-023 Latency SHALL be acceptance edge to result edge = 1 cycle; maximum throughput SHALL be one sample per 2 cycles.
REQ-024 On the first failure of a session, first_fail_index SHALL load the sample index and first_fail_valid SHALL set; later failures SHALL leave both unchanged.
REQ-025 pass_count, fail_count and the sample index SHALL saturate at all-ones and never wrap.
REQ-026 start SHALL have priority over all other inputs in every state: it clears counters, first_fail_valid, first_fail_index and mismatch, discards any sample in CHECK, and enters ARMED.
REQ-027 end_session in ARMED SHALL move the FSM to DONE. In CHECK it SHALL be latched and honoured after the check completes. In IDLE or DONE it SHALL be ignored.
REQ-028 If sample_valid and end_session are both 1 in ARMED, the sample SHALL be accepted and checked before entering DONE.
REQ-029 In IDLE and DONE, samples SHALL be ignored and counters SHALL hold their values.

Reset
REQ-030 While reset is 1, the state SHALL be IDLE and every output SHALL be 0, including counters, first_fail_index, first_fail_valid, mismatch, sample_ready, busy and session_done.
REQ-031 Reset asserted mid-CHECK SHALL abort the check with no counter update and no mismatch pulse.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-033 start; AND, a=0x2, b=0x8, out=0x0, zerof=1 -> pass_count=1, fail_count=0, mismatch never high.
REQ-034 AND, a=0x8, b=0x8, out=0x8, zerof=0, then out=0x8, zerof=1 -> pass_count=1, fail_count=1, one mismatch pulse, first_fail_index=1.
REQ-035 NOR, a=b=0x0, out=0xFFFFFFFF, zerof=0, then XOR, a=b=0x5, out=0x1 -> pass=1, fail=1; a third failing sample leaves first_fail_index=1.
REQ-036 sample_valid held high for 6 cycles -> exactly 3 samples accepted, sample_ready toggling 1,0,1,0,1,0.
REQ-037 end_session asserted in CHECK -> result counted, then session_done=1; further samples ignored; start -> counters 0, ARMED.
REQ-038 CNT_W=4 with 17 passing samples -> pass_count=0xF (saturated); reset asserted during CHECK -> all outputs 0 immediately.
